// File: rtl/score_overlay_gen.sv
// HUD overlay for the "S dddd" score row and "L dd" level row: sequential BCD conversion of
// the score, sprite ROM addressing and a 2-stage pixel pipeline. Optional macro SCORE_LZ_BLANK_EN.
module score_overlay_gen #(
    parameter int SCORE_X0  = 16,
    parameter int SCORE_Y0  = 8,
    parameter int LEVEL_X0  = 16,
    parameter int LEVEL_Y0  = 40,
    parameter int GLYPH_W   = 20,
    parameter int GLYPH_H   = 25,
    parameter int SCORE_MAX = 9999
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [13:0] score,
    input  logic        score_load,
    input  logic [6:0]  level,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic [14:0] read_address0,
    output logic [14:0] read_address1,
    input  logic [4:0]  data_Out0,
    input  logic [4:0]  data_Out1,
    output logic        busy,
    output logic        pixel_on,
    output logic [4:0]  pixel_color
);

    localparam logic [14:0] GLYPH_WORDS = 15'(GLYPH_W * GLYPH_H);
    localparam logic [9:0]  S_X0 = 10'(SCORE_X0);
    localparam logic [9:0]  S_X1 = 10'(SCORE_X0 + 5 * GLYPH_W);
    localparam logic [9:0]  S_Y0 = 10'(SCORE_Y0);
    localparam logic [9:0]  S_Y1 = 10'(SCORE_Y0 + GLYPH_H);
    localparam logic [9:0]  L_X0 = 10'(LEVEL_X0);
    localparam logic [9:0]  L_X1 = 10'(LEVEL_X0 + 3 * GLYPH_W);
    localparam logic [9:0]  L_Y0 = 10'(LEVEL_Y0);
    localparam logic [9:0]  L_Y1 = 10'(LEVEL_Y0 + GLYPH_H);
    localparam logic [3:0]  GLYPH_L = 4'd10;
    localparam logic [3:0]  GLYPH_S = 4'd11;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t      state_reg;
    logic [13:0] bin_reg;
    logic [15:0] bcd_reg;
    logic [3:0]  iter_reg;
    logic        pend_reg;
    logic [13:0] pend_val_reg;
    logic [15:0] digit_reg;
    logic [3:0]  lvl_tens_reg;
    logic [3:0]  lvl_ones_reg;
    logic        busy_reg;

    logic [13:0] score_sat;
    logic [15:0] bcd_adj;

    assign score_sat = (score > 14'(SCORE_MAX)) ? 14'(SCORE_MAX) : score;

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dabble
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    logic [6:0] lvl_sat;
    logic [3:0] lvl_tens_c;
    logic [3:0] lvl_ones_c;

    assign lvl_sat = (level > 7'd99) ? 7'd99 : level;

    always_comb begin
        lvl_tens_c = 4'd0;
        lvl_ones_c = lvl_sat[3:0];
        for (int k = 1; k < 10; k++) begin
            if (lvl_sat >= 7'(k * 10)) begin
                lvl_tens_c = 4'(k);
                lvl_ones_c = 4'(lvl_sat - 7'(k * 10));
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg    <= IDLE;
            bin_reg      <= '0;
            bcd_reg      <= '0;
            iter_reg     <= '0;
            pend_reg     <= 1'b0;
            pend_val_reg <= '0;
            digit_reg    <= '0;
            lvl_tens_reg <= '0;
            lvl_ones_reg <= '0;
            busy_reg     <= 1'b0;
        end else begin
            lvl_tens_reg <= lvl_tens_c;
            lvl_ones_reg <= lvl_ones_c;
            case (state_reg)
                IDLE: begin
                    if (score_load) begin
                        bin_reg   <= score_sat;
                        bcd_reg   <= '0;
                        iter_reg  <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_reg  <= 16'({bcd_adj, bin_reg[13]});
                    bin_reg  <= {bin_reg[12:0], 1'b0};
                    iter_reg <= iter_reg + 4'd1;
                    if (iter_reg == 4'd13) begin
                        state_reg <= COMMIT;
                    end
                    if (score_load) begin
                        pend_reg     <= 1'b1;
                        pend_val_reg <= score_sat;
                    end
                end
                COMMIT: begin
                    // All four digits change on the same edge so a frame never sees a mix.
                    digit_reg <= bcd_reg;
                    pend_reg  <= 1'b0;
                    if (score_load || pend_reg) begin
                        bin_reg   <= score_load ? score_sat : pend_val_reg;
                        bcd_reg   <= '0;
                        iter_reg  <= '0;
                        state_reg <= SHIFT;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;

    logic [9:0]  dx0, dy0, col0;
    logic [2:0]  slot0;
    logic [3:0]  glyph0;
    logic        hit0_c;
    logic        blank0_c;
    logic [14:0] addr0_c;

    assign dx0    = DrawX - S_X0;
    assign dy0    = DrawY - S_Y0;
    assign hit0_c = (DrawX >= S_X0) && (DrawX < S_X1) && (DrawY >= S_Y0) && (DrawY < S_Y1);

    // Slot select by range compare against multiples of the glyph width.
    always_comb begin
        slot0 = 3'd0;
        col0  = dx0;
        for (int k = 1; k < 5; k++) begin
            if (dx0 >= 10'(k * GLYPH_W)) begin
                slot0 = 3'(k);
                col0  = dx0 - 10'(k * GLYPH_W);
            end
        end
    end

    always_comb begin
        case (slot0)
            3'd0:    glyph0 = GLYPH_S;
            3'd1:    glyph0 = digit_reg[15:12];
            3'd2:    glyph0 = digit_reg[11:8];
            3'd3:    glyph0 = digit_reg[7:4];
            default: glyph0 = digit_reg[3:0];
        endcase
    end

`ifdef SCORE_LZ_BLANK_EN
    logic lz_thousands, lz_hundreds, lz_tens;
    assign lz_thousands = (digit_reg[15:12] == 4'd0);
    assign lz_hundreds  = lz_thousands && (digit_reg[11:8] == 4'd0);
    assign lz_tens      = lz_hundreds && (digit_reg[7:4] == 4'd0);
    assign blank0_c     = ((slot0 == 3'd1) && lz_thousands) ||
                          ((slot0 == 3'd2) && lz_hundreds)  ||
                          ((slot0 == 3'd3) && lz_tens);
`else
    assign blank0_c = 1'b0;
`endif

    assign addr0_c = 15'(glyph0) * GLYPH_WORDS + 15'(dy0) * 15'(GLYPH_W) + 15'(col0);
    assign read_address0 = (hit0_c && Reset_n) ? addr0_c : 15'd0;

    logic [9:0]  dx1, dy1, col1;
    logic [1:0]  slot1;
    logic [3:0]  glyph1;
    logic        hit1_c;
    logic [14:0] addr1_c;

    assign dx1    = DrawX - L_X0;
    assign dy1    = DrawY - L_Y0;
    assign hit1_c = (DrawX >= L_X0) && (DrawX < L_X1) && (DrawY >= L_Y0) && (DrawY < L_Y1);

    always_comb begin
        slot1 = 2'd0;
        col1  = dx1;
        for (int k = 1; k < 3; k++) begin
            if (dx1 >= 10'(k * GLYPH_W)) begin
                slot1 = 2'(k);
                col1  = dx1 - 10'(k * GLYPH_W);
            end
        end
    end

    always_comb begin
        case (slot1)
            2'd0:    glyph1 = GLYPH_L;
            2'd1:    glyph1 = lvl_tens_reg;
            default: glyph1 = lvl_ones_reg;
        endcase
    end

    assign addr1_c = 15'(glyph1) * GLYPH_WORDS + 15'(dy1) * 15'(GLYPH_W) + 15'(col1);
    assign read_address1 = (hit1_c && Reset_n) ? addr1_c : 15'd0;

    logic hit0_reg, hit1_reg, blank0_reg;
    logic on0, on1;

    assign on0 = hit0_reg && !blank0_reg && (data_Out0 != 5'd0);
    assign on1 = hit1_reg && (data_Out1 != 5'd0);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hit0_reg    <= 1'b0;
            hit1_reg    <= 1'b0;
            blank0_reg  <= 1'b0;
            pixel_on    <= 1'b0;
            pixel_color <= '0;
        end else begin
            hit0_reg    <= hit0_c;
            hit1_reg    <= hit1_c;
            blank0_reg  <= blank0_c;
            pixel_on    <= on0 || on1;
            pixel_color <= on0 ? data_Out0 : (on1 ? data_Out1 : 5'd0);
        end
    end

endmodule

// File: tb/tb_score_overlay_gen.sv
// Scoreboard bench for score_overlay_gen: ROM model, address checks and 2-cycle pixel checks.
module tb_score_overlay_gen;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [13:0] score;
    logic        score_load;
    logic [6:0]  level;
    logic [9:0]  DrawX, DrawY;
    logic [14:0] read_address0, read_address1;
    logic [4:0]  data_Out0 = '0;
    logic [4:0]  data_Out1 = '0;
    logic        busy, pixel_on;
    logic [4:0]  pixel_color;

    always #5 Clk = ~Clk;

    score_overlay_gen dut (
        .Clk(Clk), .Reset_n(Reset_n), .score(score), .score_load(score_load),
        .level(level), .DrawX(DrawX), .DrawY(DrawY),
        .read_address0(read_address0), .read_address1(read_address1),
        .data_Out0(data_Out0), .data_Out1(data_Out1),
        .busy(busy), .pixel_on(pixel_on), .pixel_color(pixel_color)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int rom1_ovr = -1;
    int exp_score = 0;
    int exp_level = 0;

    typedef struct {
        int due;
        bit on;
        int color;
    } pix_exp_t;
    pix_exp_t pq[$];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic logic [4:0] rom_fn(input logic [14:0] a);
        int v = int'(a);
        if (v % 13 == 0) return 5'd0;
        return 5'((v % 31) + 1);
    endfunction

    always @(posedge Clk) cyc <= cyc + 1;

    always @(posedge Clk) begin
        data_Out0 <= rom_fn(read_address0);
        data_Out1 <= (rom1_ovr >= 0) ? 5'(rom1_ovr) : rom_fn(read_address1);
    end

    pix_exp_t e;
    always @(negedge Clk) begin
        while (pq.size() > 0 && pq[0].due <= cyc) begin
            e = pq.pop_front();
            check("pixel_on", int'(pixel_on), int'(e.on));
            check("pixel_color", int'(pixel_color), e.color);
        end
    end

    function automatic void model_pix(input int x, input int y, output int a0, output int a1,
                                      output bit h0, output bit h1, output bit bl0);
        int slot, g, sc, lv;
        sc = exp_score;
        lv = exp_level;
        h0 = (x >= 16) && (x < 116) && (y >= 8) && (y < 33);
        slot = (x - 16) / 20;
        case (slot)
            0: g = 11;
            1: g = sc / 1000;
            2: g = (sc / 100) % 10;
            3: g = (sc / 10) % 10;
            default: g = sc % 10;
        endcase
        a0 = h0 ? g * 500 + (y - 8) * 20 + (x - 16) % 20 : 0;
`ifdef SCORE_LZ_BLANK_EN
        bl0 = h0 && ((slot == 1 && sc < 1000) || (slot == 2 && sc < 100) || (slot == 3 && sc < 10));
`else
        bl0 = 1'b0;
`endif
        h1 = (x >= 16) && (x < 76) && (y >= 40) && (y < 65);
        slot = (x - 16) / 20;
        g = (slot == 0) ? 10 : ((slot == 1) ? lv / 10 : lv % 10);
        a1 = h1 ? g * 500 + (y - 40) * 20 + (x - 16) % 20 : 0;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic pix(input int x, input int y);
        int a0, a1, d0, d1;
        bit h0, h1, bl0, on0, on1;
        pix_exp_t p;
        DrawX = 10'(x);
        DrawY = 10'(y);
        #1;
        model_pix(x, y, a0, a1, h0, h1, bl0);
        check("read_address0", int'(read_address0), a0);
        check("read_address1", int'(read_address1), a1);
        d0 = int'(rom_fn(15'(a0)));
        d1 = (rom1_ovr >= 0) ? rom1_ovr : int'(rom_fn(15'(a1)));
        on0 = h0 && !bl0 && d0 != 0;
        on1 = h1 && d1 != 0;
        p.due   = cyc + 2;
        p.on    = on0 || on1;
        p.color = on0 ? d0 : (on1 ? d1 : 0);
        pq.push_back(p);
        $display("pix x=%0d y=%0d addr0=%0d addr1=%0d on=%0d color=%0d", x, y, a0, a1, p.on, p.color);
        step();
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && pq.size() > 0; i++) step();
        if (pq.size() > 0) check("pixel_queue_drain", pq.size(), 0);
    endtask

    task automatic scan_digits();
        for (int s = 0; s < 5; s++) pix(16 + s * 20 + 7, 8 + 3);
        for (int s = 0; s < 3; s++) pix(16 + s * 20 + 2, 40 + 10);
        drain();
    endtask

    task automatic pulse_load(input int v);
        score = 14'(v);
        score_load = 1'b1;
        step();
        score_load = 1'b0;
    endtask

    // Watches the ones glyph every cycle: old digit until the commit edge, new digit after.
    task automatic load_watch(input int v);
        int a_old, a_new, a1;
        bit h0, h1, bl0;
        DrawX = 10'(96);
        DrawY = 10'(8);
        model_pix(96, 8, a_old, a1, h0, h1, bl0);
        pulse_load(v);
        for (int i = 1; i <= 15; i++) begin
            check("busy_converting", int'(busy), 1);
            check("digits_held", int'(read_address0), a_old);
            step();
        end
        exp_score = (v > 9999) ? 9999 : v;
        model_pix(96, 8, a_new, a1, h0, h1, bl0);
        check("busy_done", int'(busy), 0);
        check("digits_committed", int'(read_address0), a_new);
        $display("load %0d -> displayed %0d", v, exp_score);
    endtask

    int sx[7] = '{15, 16, 35, 36, 59, 115, 116};
    int sy[4] = '{7, 8, 32, 33};
    int lx[5] = '{15, 16, 61, 75, 76};
    int ly[3] = '{40, 64, 65};
    int ok;

    initial begin
        Reset_n = 1'b0;
        score = '0;
        score_load = 1'b0;
        level = '0;
        DrawX = 10'd16;
        DrawY = 10'd8;
        step();
        step();
        check("reset_busy", int'(busy), 0);
        check("reset_pixel_on", int'(pixel_on), 0);
        check("reset_pixel_color", int'(pixel_color), 0);
        check("reset_read_address0", int'(read_address0), 0);
        check("reset_read_address1", int'(read_address1), 0);
        Reset_n = 1'b1;
        step();

        // Frame edges for both rows with the reset digits.
        pix(16, 8);
        foreach (sy[j]) foreach (sx[i]) pix(sx[i], sy[j]);
        foreach (ly[j]) foreach (lx[i]) pix(lx[i], ly[j]);
        drain();

        load_watch(1234);
        pix(16 + 43, 8 + 4);
        scan_digits();

        load_watch(12000);
        scan_digits();

        // Back-to-back loads: the ones glyph may only ever show 9, 0 or 7.
        DrawX = 10'(96);
        DrawY = 10'(8);
        pulse_load(500);
        repeat (4) step();
        pulse_load(77);
        for (int i = 0; i < 80 && busy; i++) begin
            ok = (read_address0 == 15'd4500 || read_address0 == 15'd0 || read_address0 == 15'd3500) ? 1 : 0;
            check("no_torn_digits", ok, 1);
            step();
        end
        check("pending_busy_done", int'(busy), 0);
        exp_score = 77;
        scan_digits();

        level = 7'd7;
        step();
        step();
        exp_level = 7;
        rom1_ovr = 0;
        pix(16 + 45, 40);
        drain();
        rom1_ovr = 9;
        pix(16 + 45, 40);
        drain();
        rom1_ovr = -1;
        level = 7'd120;
        step();
        step();
        exp_level = 99;
        scan_digits();

        // Reset in the middle of a conversion.
        pulse_load(3333);
        repeat (6) step();
        Reset_n = 1'b0;
        DrawX = 10'(96);
        DrawY = 10'(8);
        #1;
        check("midreset_busy", int'(busy), 0);
        check("midreset_pixel_on", int'(pixel_on), 0);
        check("midreset_read_address0", int'(read_address0), 0);
        step();
        Reset_n = 1'b1;
        exp_score = 0;
        step();
        step();
        check("after_reset_busy", int'(busy), 0);
        scan_digits();
        load_watch(10);
        scan_digits();

        drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
